// File: rtl/load_seq_pkg.sv
// Shared types and helpers for the load sequencer.
package load_seq_pkg;

    // Widest channel bank the one-hot helper can address.
    localparam int OH_MAX = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        LOAD  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    // One-hot decode of idx; out-of-range indices give all zeros.
    function automatic logic [OH_MAX-1:0] onehot(input int unsigned idx, input int unsigned n);
        return (idx < n) ? (OH_MAX'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Per-word wait timer: saturating counter, expired flags the last allowed wait cycle.
module seq_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic [TW-1:0] count;

    // Count wait cycles; clear wins over enable, and the count holds at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != '1))
            count <= count + TW'(1);
    end

    // TIMEOUT of zero means never expire.
    assign expired = (TIMEOUT != 0) && (count == LAST);

endmodule

// File: rtl/load_sequencer.sv
// Sequences NUM_CH handshaked word loads into a register bank, one-hot strobe per word.
module load_sequencer
    import load_seq_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int TIMEOUT = 255,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              inputdata_ready,
    output logic              loaddata,
    output logic [NUM_CH-1:0] load_sel,
    output logic [CH_W-1:0]   ch_idx,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_t          state;
    state_t          nxt;
    logic [CH_W-1:0] nxt_ch;
    logic            start_acc;
    logic            expired;
    logic            tmr_clear;
    logic            tmr_en;

    // The timer only runs while waiting for a word; it restarts at every entry to WAIT.
    assign tmr_clear = abort || (state != WAIT);
    assign tmr_en    = (state == WAIT) && !inputdata_ready;

    seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (expired)
    );

    assign start_acc = !abort && (state == IDLE) && start;

    // Next state and channel; abort overrides everything, ready beats a same-cycle timeout.
    always_comb begin
        nxt    = state;
        nxt_ch = ch_idx;
        if (abort) begin
            nxt    = IDLE;
            nxt_ch = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        nxt    = WAIT;
                        nxt_ch = '0;
                    end
                end
                WAIT: begin
                    if (inputdata_ready)
                        nxt = LOAD;
                    else if (expired)
                        nxt = ERROR;
                end
                LOAD: begin
                    if (ch_idx == LAST_CH) begin
                        nxt = DONE;
                    end else begin
                        nxt    = WAIT;
                        nxt_ch = ch_idx + CH_W'(1);
                    end
                end
                DONE: begin
                    nxt    = mode ? WAIT : IDLE;
                    nxt_ch = '0;
                end
                ERROR: begin
                    nxt    = IDLE;
                    nxt_ch = '0;
                end
                default: begin
                    nxt    = IDLE;
                    nxt_ch = '0;
                end
            endcase
        end
    end

    // State register with outputs registered from the next state, so nothing is combinational from inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ch_idx      <= '0;
            loaddata    <= 1'b0;
            load_sel    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= nxt;
            ch_idx   <= nxt_ch;
            loaddata <= (nxt == LOAD);
            load_sel <= (nxt == LOAD) ? NUM_CH'(onehot(32'(nxt_ch), NUM_CH)) : '0;
            busy     <= (nxt == WAIT) || (nxt == LOAD) || (nxt == DONE);
            done     <= (nxt == DONE);
            if (start_acc)
                timeout_err <= 1'b0;
            else if (nxt == ERROR)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed + random bench for load_sequencer against a word-level behavioural model.
module tb_load_sequencer;

    localparam int N = 4;
    localparam int T = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         abort = 1'b0;
    logic         rdy = 1'b0;
    logic         loaddata;
    logic [N-1:0] load_sel;
    logic [1:0]   ch_idx;
    logic         busy;
    logic         done;
    logic         terr;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model: running = a pass is in progress (busy); loading/done/err pulses; word = current channel.
    bit m_run, m_load, m_donep, m_errp, m_terr;
    int m_word, m_waited;

    always #5 clk = ~clk;

    load_sequencer #(.NUM_CH(N), .TIMEOUT(T)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .mode            (mode),
        .abort           (abort),
        .inputdata_ready (rdy),
        .loaddata        (loaddata),
        .load_sel        (load_sel),
        .ch_idx          (ch_idx),
        .busy            (busy),
        .done            (done),
        .timeout_err     (terr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_load = 0; m_donep = 0; m_errp = 0; m_terr = 0;
        m_word = 0; m_waited = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        if (abort) begin
            m_run = 0; m_load = 0; m_donep = 0; m_errp = 0; m_word = 0; m_waited = 0;
        end else if (m_errp) begin
            m_errp = 0; m_word = 0;
        end else if (m_donep) begin
            m_donep = 0; m_word = 0; m_waited = 0;
            m_run = mode;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_word = 0; m_waited = 0; m_terr = 0;
            end
        end else if (m_load) begin
            m_load = 0;
            if (m_word == N - 1) m_donep = 1;
            else begin
                m_word++;
                m_waited = 0;
            end
        end else begin
            if (rdy) m_load = 1;
            else if (m_waited == T - 1) begin
                m_run = 0; m_errp = 1; m_terr = 1;
            end else m_waited++;
        end
    endtask

    task automatic compare_all();
        check("loaddata", 32'(loaddata), 32'(m_load));
        check("load_sel", 32'(load_sel), m_load ? (32'd1 << m_word) : 32'd0);
        check("ch_idx", 32'(ch_idx), 32'(m_word));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_donep));
        check("timeout_err", 32'(terr), 32'(m_terr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        compare_all();
    endtask

    // Tick until DUT shows a load of channel ch; bounded.
    task automatic wait_load(input int ch, output bit ok);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (loaddata && (32'(ch_idx) == ch)) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy && !terr && !loaddata && !done) begin
                ok = 1;
                break;
            end
            if (!busy && terr) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, last_done, n_done, thr;

        // Reset state
        model_reset();
        #2;
        check("rst_loaddata", 32'(loaddata), 0);
        check("rst_load_sel", 32'(load_sel), 0);
        check("rst_ch_idx", 32'(ch_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_terr", 32'(terr), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        // Single pass, ready held high: loads in cycles 2,4,6,8, done in cycle 9
        mode = 0; rdy = 1; start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 10; k++) begin
            check("sp_load", 32'(loaddata), 32'((k % 2 == 0) && (k <= 8)));
            check("sp_done", 32'(done), 32'(k == 9));
            check("sp_busy", 32'(busy), 32'((k >= 1) && (k <= 9)));
            if ((k % 2 == 0) && (k <= 8))
                check("sp_sel", 32'(load_sel), 32'd1 << (k / 2 - 1));
            tick();
        end

        // Stalled handshake before word 2
        rdy = 1; start = 1;
        tick();
        start = 0;
        wait_load(1, ok);
        check("stall_reach_w1", 32'(ok), 1);
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_noload", 32'(loaddata), 0);
        end
        rdy = 1;
        tick();
        check("stall_load_after_ready", 32'(loaddata), 1);
        check("stall_ch2", 32'(ch_idx), 2);
        n = 0;
        while (!done && n < 10) begin
            tick();
            n++;
        end
        check("stall_done_seen", 32'(done), 1);
        check("stall_no_err", 32'(terr), 0);
        tick();

        // Timeout after word 0
        rdy = 1; start = 1;
        tick();
        start = 0;
        wait_load(0, ok);
        check("to_reach_w0", 32'(ok), 1);
        rdy = 0;
        n = 0;
        while (!terr && n < 20) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 9);
        check("to_busy", 32'(busy), 0);
        check("to_done", 32'(done), 0);
        tick();
        check("to_sticky", 32'(terr), 1);
        tick();
        check("to_sticky2", 32'(terr), 1);
        start = 1;
        tick();
        start = 0;
        check("to_cleared", 32'(terr), 0);
        check("to_restart_busy", 32'(busy), 1);
        rdy = 1;
        wait_idle(ok);
        check("to_recover_idle", 32'(ok), 1);

        // Continuous mode: done every 9 cycles
        mode = 1; rdy = 1; start = 1;
        tick();
        start = 0;
        last_done = -1; n_done = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                if (last_done >= 0) check("cont_period", 32'(cyc - last_done), 9);
                last_done = cyc;
                n_done++;
            end
        end
        check("cont_passes", 32'(n_done >= 3), 1);
        mode = 0;
        wait_idle(ok);
        check("cont_stop_idle", 32'(ok), 1);

        // Abort during LOAD of channel 1
        rdy = 1; start = 1;
        tick();
        start = 0;
        wait_load(1, ok);
        check("ab_reach_w1", 32'(ok), 1);
        abort = 1;
        tick();
        abort = 0;
        check("ab_busy", 32'(busy), 0);
        check("ab_sel", 32'(load_sel), 0);
        check("ab_done", 32'(done), 0);
        check("ab_ch", 32'(ch_idx), 0);
        start = 1;
        tick();
        start = 0;
        tick();
        check("ab_restart_load", 32'(loaddata), 1);
        check("ab_restart_ch", 32'(ch_idx), 0);
        wait_idle(ok);
        check("ab_idle", 32'(ok), 1);

        // Async reset mid-pass while waiting for channel 2
        rdy = 1; start = 1;
        tick();
        start = 0;
        wait_load(1, ok);
        check("rm_reach_w1", 32'(ok), 1);
        rdy = 0;
        tick();
        check("rm_ch2", 32'(ch_idx), 2);
        check("rm_busy", 32'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("rm_loaddata", 32'(loaddata), 0);
        check("rm_ch", 32'(ch_idx), 0);
        check("rm_busy0", 32'(busy), 0);
        check("rm_sel", 32'(load_sel), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        check("rm_stay_idle", 32'(busy), 0);

        // Random traffic with varying ready density
        thr = 7;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) thr = $urandom_range(0, 10);
            start = ($urandom_range(0, 3) == 0);
            mode  = $urandom_range(0, 1);
            abort = ($urandom_range(0, 31) == 0);
            rdy   = ($urandom_range(0, 9) < thr);
            tick();
        end
        start = 0; abort = 0; rdy = 0; mode = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/load_sequencer.md
Name: load_sequencer

Overview:
Parametrised successor to the single-load control unit. Sequences the loading of NUM_CH data words into a datapath register bank. Each word is gated by the inputdata_ready handshake and gets a one-hot per-channel load strobe. Adds single/continuous mode, a per-word timeout with a sticky error flag, a synchronous abort, and a done pulse. Sits between the input interface and the datapath register bank.

Parameters:
NUM_CH, 4, number of channels/words per pass (>=1)
TIMEOUT, 255, max cycles to wait for inputdata_ready per word; 0 disables timeout
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a pass; sampled only in IDLE
mode  in  1  0 = single pass, 1 = continuous (restart after DONE); sampled in DONE
abort  in  1  synchronous abort, highest priority after reset
inputdata_ready  in  1  source has a valid word
loaddata  out  1  global load strobe, high one cycle per word
load_sel  out  NUM_CH  one-hot channel strobe, equals onehot(ch_idx) while loaddata=1, else 0
ch_idx  out  CH_W  current channel index
busy  out  1  high in WAIT, LOAD, DONE
done  out  1  one-cycle pulse at end of every pass
timeout_err  out  1  sticky timeout flag

Behaviour:
- reset low (async): state=IDLE, ch_idx=0, timer=0, timeout_err=0. All outputs 0.
- Moore FSM with registered state. Outputs decode from state only; no combinational path from inputs to outputs.
- IDLE:
  - start=1 -> WAIT, ch_idx=0, timer=0, timeout_err cleared.
  - start=0 -> stay.
- WAIT:
  - inputdata_ready=1 -> LOAD.
  - Otherwise timer++. If TIMEOUT!=0 and timer==TIMEOUT-1 with ready still 0 -> ERROR.
  - If ready arrives in the same cycle the timer expires, ready wins (-> LOAD).
- LOAD:
  - loaddata=1, load_sel=onehot(ch_idx), for exactly one cycle. inputdata_ready is ignored.
  - ch_idx==NUM_CH-1 -> DONE.
  - Otherwise ch_idx++ and -> WAIT; timer cleared.
- DONE:
  - done=1 for one cycle.
  - mode=1 -> WAIT with ch_idx=0, timer=0.
  - mode=0 -> IDLE, ch_idx=0.
- ERROR:
  - One cycle; timeout_err set, then -> IDLE, ch_idx=0. No done pulse.
  - timeout_err stays high until the next accepted start.
- abort=1 in any state -> IDLE next cycle, ch_idx=0, timer=0, no done. timeout_err unchanged.
- Latency: inputdata_ready high at edge N -> loaddata high in cycle N+1. Minimum 2 cycles per word; pass length >= 2*NUM_CH+1 cycles.
- NUM_CH=1: ch_idx is constant 0 and LOAD always goes to DONE.
- Timer width: $clog2(TIMEOUT+1), minimum 1. The timer saturates and never wraps.
- start while busy is ignored; mode changes take effect only at DONE.

Decomposition:
- Package load_seq_pkg holds:
  - state enum state_t {IDLE, WAIT, LOAD, DONE, ERROR}, 3-bit, explicit encoding.
  - function onehot(idx, n).
- One sub-module, seq_timer: clear/enable/expired, parametrised by TIMEOUT.
- Testbench module tb_load_sequencer.

Test Plan:
(bench uses NUM_CH=4, TIMEOUT=8)
- Reset mid-pass: drop reset while ch_idx=2 in WAIT -> all outputs 0 immediately (async); after release stays IDLE, ch_idx=0.
- Single pass, ready held high: start pulse, mode=0 -> loaddata high cycles 2, 4, 6, 8 with load_sel 0001, 0010, 0100, 1000; done pulse at cycle 9; then IDLE, busy=0.
- Stalled handshake: ready low 5 cycles before word 2 -> no loaddata during the stall; load 1 cycle after ready rises; pass completes with no error.
- Timeout: ready never rises after word 1 -> timeout_err=1 after 8 WAIT cycles, no done, IDLE; next start clears timeout_err.
- Continuous mode: mode=1, ready held high -> done pulses every 9 cycles and ch_idx wraps 3->0; set mode=0 -> returns to IDLE after the current pass.
- Abort during LOAD of ch 1 -> IDLE next cycle, no done, load_sel=0; new start begins at ch 0.
